// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// No logic inside. The interface only bundles the signals.
// The loader pulls bytes with in_valid/in_ready and pushes words with a one-cycle we strobe.
interface im_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  // Host side: sources the byte stream and observes the memory writes.
  modport master (
    output in_valid, in_byte,
    input  in_ready, we, waddr, wdata
  );

  // Loader side: consumes the byte stream and drives the memory writes.
  modport slave (
    input  in_valid, in_byte,
    output in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/im_loader.sv
// Boot loader: turns a length-prefixed big-endian byte stream into instruction-memory word writes.
// Latency: we fires 1 cycle after the 4th byte of a word. done/busy-fall follow 1 cycle after the last we.
// Backpressure: in_ready is registered and high only in LEN_HI/LEN_LO/DATA. Upstream stalls only pause the loader.
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  im_loader_if.slave  bus,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, FLUSH, DONE, ERR} state_t;

  localparam logic [16:0] DepthLim = 17'(DEPTH);

  state_t      state;
  logic [7:0]  lenHi;
  logic [15:0] lenWords;
  logic [23:0] shiftReg;   // the three earlier bytes of the word being assembled
  logic [1:0]  byteCnt;
  logic [12:0] index;      // 13 bits so that a full DEPTH=4096 load fits

  logic        accept;
  logic [15:0] lenNext;
  logic [31:0] wordNext;
  logic        lastWord;

  assign accept   = bus.in_valid && bus.in_ready;
  assign lenNext  = {lenHi, bus.in_byte};
  assign wordNext = {shiftReg, bus.in_byte};
  assign lastWord = ({3'b000, index} == (lenWords - 16'd1));

  // The CPU is held for exactly as long as a load is in progress.
  assign cpu_hold = busy;

  // Load sequencer. Every output is registered, and we is cleared each cycle unless a word completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      lenHi        <= 8'h00;
      lenWords     <= 16'h0000;
      shiftReg     <= 24'h000000;
      byteCnt      <= 2'd0;
      index        <= 13'd0;
      bus.in_ready <= 1'b0;
      bus.we       <= 1'b0;
      bus.waddr    <= BASE_ADDR;
      bus.wdata    <= 32'h0000_0000;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN_HI;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            index        <= 13'd0;
            byteCnt      <= 2'd0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            lenHi <= bus.in_byte;
            state <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            lenWords <= lenNext;
            if (lenNext == 16'd0) begin
              state        <= DONE;
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
            end else if ({1'b0, lenNext} > DepthLim) begin
              // Oversized image: refuse the rest of the stream.
              state        <= ERR;
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
              err          <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            shiftReg <= wordNext[23:0];
            byteCnt  <= byteCnt + 2'd1;
            if (byteCnt == 2'd3) begin
              bus.we    <= 1'b1;
              bus.wdata <= wordNext;
              bus.waddr <= BASE_ADDR + {17'd0, index, 2'b00};
              index     <= index + 13'd1;
              if (lastWord) begin
                // The final write is issued during FLUSH. After that, the CPU is released.
                state        <= FLUSH;
                bus.in_ready <= 1'b0;
              end
            end
          end
        end
        FLUSH: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
